contador_multi: RTL and testbench
=================================

# contador_multi

Parametrised pop-counter bank with a registered read port. It counts pop pulses on `NUM_CH` independent channels with saturating arithmetic and per-channel sticky overflow. A requester reads any channel through a req/valid/ack handshake gated by `idle`. It sits beside the FIFO array and serves the same statistics-readout role as the fixed five-channel counter, at arbitrary width and depth.

## Interface
- `NUM_CH`, 5: number of counted channels (1..16)
- `CNT_W`, 6: counter width in bits, same for all channels
- `IDX_W`, 3: index width; must satisfy 2^IDX_W >= NUM_CH

- `clk`  in  1  single clock, rising edge
- `reset_L`  in  1  reset, asynchronous, active-low
- `pop`  in  NUM_CH  per-channel pop strobe; bit i increments counter i
- `idle`  in  1  system idle; reads are accepted only while high
- `req`  in  1  read request
- `idx`  in  IDX_W  channel selected by the request
- `ack`  in  1  requester consumes the response
- `valid`  out  1  response held valid
- `data_out`  out  CNT_W  counter value of the selected channel
- `ovf`  out  1  sticky overflow flag of the selected channel
- `err`  out  1  request carried an out-of-range `idx` (>= NUM_CH)

## Operation
- Counters: CNT_W bits each. Reset value 0.
- `pop[i]`=1 at a rising edge: counter i increments by 1.
- Counter at all-ones: it stays at all-ones (saturates) and `ovf_i` sets. `ovf_i` is sticky until reset or clear.
- All channels count every cycle, independent of `idle`, `req`, and FSM state.
- FSM has two states: `ST_WAIT` (reset state) and `ST_RESP`.
- `ST_WAIT`: `idle`=1 and `req`=1 at an edge means the request is accepted.
  - Capture `data_out` = counter[idx] and `ovf` = ovf[idx], using the value before any same-cycle pop.
  - Set `valid`=1 and `err`=0, then move to `ST_RESP`.
- `ST_WAIT` with idx >= NUM_CH: accepted the same way, with `data_out`=0, `ovf`=0, `err`=1, `valid`=1. Move to `ST_RESP`.
- `ST_WAIT` with `req`=1 and `idle`=0: no action. The request is not queued.
- `ST_RESP`: all outputs hold stable. `req` and `idx` are ignored.
- `ST_RESP` with `ack`=1 at an edge: `valid`, `err`, and `ovf` go to 0, `data_out` goes to 0, and the FSM returns to `ST_WAIT`.
- `ack` while in `ST_WAIT`: ignored.
- Reset asserted at any time: all counters, overflow flags, FSM state, and outputs clear immediately (asynchronous). A pending response is dropped.
- Reset values: `valid`=0, `data_out`=0, `ovf`=0, `err`=0.

## Timing
- Read latency is 1 cycle: request sampled at edge N, `valid` high after edge N.
- Maximum read throughput is one read per 2 cycles. `ack` at edge N+1 allows a new accept at edge N+2.
- `valid` falls at the edge where `ack` is sampled high.
- A pop at the same edge as an accept is visible only in a later read.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `CONTADOR_CLR_ON_READ_EN` defined: accepting a valid-index read clears counter[idx] and ovf[idx] at the accept edge.
  - If `pop[idx]` is high at that same edge, the counter becomes 1 and ovf becomes 0.
  - Reads with `err`=1 clear nothing.
- `CONTADOR_CLR_ON_READ_EN` undefined: reads are non-destructive. Counters change only by pop or reset.

## Structure
- Package `contador_pkg` holds:
  - state encoding constants `ST_WAIT`=1'b0 and `ST_RESP`=1'b1
  - default values for `NUM_CH`, `CNT_W`, `IDX_W`
- Sub-module `contador_canal`: one saturating counter plus sticky ovf flag, with `pop` and `clr` inputs. Instantiated `NUM_CH` times in a generate loop.
- The top level holds the FSM, the read mux, and the output registers.

## Test plan
- Reset, then pop[2] for 7 cycles, idle=1, req=1, idx=2 → next cycle valid=1, data_out=7, ovf=0, err=0. Outputs hold until ack, then valid=0.
- CNT_W=6, 70 pops on channel 0, read idx=0 → data_out=63, ovf=1.
- idx=5 with NUM_CH=5, idle=1, req=1 → valid=1, err=1, data_out=0. No counter changes.
- idle=0, req=1 for 3 cycles → valid stays 0. Raise idle → accepted at the next edge.
- Simultaneous pop[1] and read of idx=1 (count 4):
  - macro undefined: data_out=4, later read 5.
  - `CONTADOR_CLR_ON_READ_EN` defined: data_out=4, later read 1.
- reset_L low mid-`ST_RESP` (valid=1, data_out=9) → valid=0 and data_out=0 immediately, all counters read 0 afterward.

Source files
------------

// File: rtl/contador_pkg.sv
// Shared definitions for the contador_multi pop-counter bank: FSM encoding and default sizes.
package contador_pkg;

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    localparam int DEF_NUM_CH = 5;
    localparam int DEF_CNT_W  = 6;
    localparam int DEF_IDX_W  = 3;

endpackage

// File: rtl/contador_canal.sv
// One saturating pop counter with a sticky overflow flag; clr wins over the stored value,
// and a pop coincident with clr still counts.
module contador_canal #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             pop,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= pop ? CNT_W'(1) : '0;
            ovf <= 1'b0;
        end else if (pop) begin
            // A pop that finds the counter already full is the overflow event.
            if (cnt == CNT_MAX) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/contador_multi.sv
// Pop-counter bank with a registered req/valid/ack read port gated by idle.
// Define CONTADOR_CLR_ON_READ_EN to make accepted in-range reads clear the selected channel.
module contador_multi
    import contador_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int IDX_W  = DEF_IDX_W
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [NUM_CH-1:0] pop,
    input  logic              idle,
    input  logic              req,
    input  logic [IDX_W-1:0]  idx,
    input  logic              ack,
    output logic              valid,
    output logic [CNT_W-1:0]  data_out,
    output logic              ovf,
    output logic              err
);

    localparam logic [IDX_W:0] NUM_CH_L = (IDX_W + 1)'(NUM_CH);

    state_t            state;
    logic [CNT_W-1:0]  cnt_arr [NUM_CH];
    logic [NUM_CH-1:0] ovf_vec;
    logic [NUM_CH-1:0] clr_vec;
    logic [CNT_W-1:0]  sel_cnt;
    logic              sel_ovf;
    logic              in_range;
    logic              accept;

    assign accept   = (state == ST_WAIT) && idle && req;
    assign in_range = ({1'b0, idx} < NUM_CH_L);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_canal
`ifdef CONTADOR_CLR_ON_READ_EN
        assign clr_vec[i] = accept && in_range && (idx == IDX_W'(i));
`else
        assign clr_vec[i] = 1'b0;
`endif
        contador_canal #(.CNT_W(CNT_W)) u_canal (
            .clk    (clk),
            .reset_L(reset_L),
            .pop    (pop[i]),
            .clr    (clr_vec[i]),
            .cnt    (cnt_arr[i]),
            .ovf    (ovf_vec[i])
        );
    end

    // Read mux sees pre-edge counter values, so a same-edge pop shows up only in later reads.
    always_comb begin
        sel_cnt = '0;
        sel_ovf = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_cnt = cnt_arr[i];
                sel_ovf = ovf_vec[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state    <= ST_WAIT;
            valid    <= 1'b0;
            data_out <= '0;
            ovf      <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (accept) begin
                        state <= ST_RESP;
                        valid <= 1'b1;
                        if (in_range) begin
                            data_out <= sel_cnt;
                            ovf      <= sel_ovf;
                            err      <= 1'b0;
                        end else begin
                            data_out <= '0;
                            ovf      <= 1'b0;
                            err      <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (ack) begin
                        state    <= ST_WAIT;
                        valid    <= 1'b0;
                        data_out <= '0;
                        ovf      <= 1'b0;
                        err      <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_contador_multi.sv
// Directed bench for contador_multi with hand-computed expectations (NUM_CH=5, CNT_W=6, IDX_W=3).
module tb_contador_multi;

    localparam int NUM_CH = 5;
    localparam int CNT_W  = 6;
    localparam int IDX_W  = 3;

    logic              clk = 1'b0;
    logic              reset_L;
    logic [NUM_CH-1:0] pop;
    logic              idle;
    logic              req;
    logic [IDX_W-1:0]  idx;
    logic              ack;
    logic              valid;
    logic [CNT_W-1:0]  data_out;
    logic              ovf;
    logic              err;

    int n_tests = 0;
    int n_fail  = 0;

    contador_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .pop     (pop),
        .idle    (idle),
        .req     (req),
        .idx     (idx),
        .ack     (ack),
        .valid   (valid),
        .data_out(data_out),
        .ovf     (ovf),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs and checks happen 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input int ch);
        idle = 1'b1;
        req  = 1'b1;
        idx  = IDX_W'(ch);
        tick();
        req  = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        reset_L = 1'b0;
        pop     = '0;
        idle    = 1'b0;
        req     = 1'b0;
        idx     = '0;
        ack     = 1'b0;
        tick();
        tick();
        chk("rst_valid", valid, 0);
        chk("rst_data", data_out, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_err", err, 0);
        reset_L = 1'b1;
        tick();

        // Seven pops on channel 2, then a read that must hold until ack.
        pop = 5'b00100;
        repeat (7) tick();
        pop = '0;
        do_read(2);
        chk("rd2_valid", valid, 1);
        chk("rd2_data", data_out, 7);
        chk("rd2_ovf", ovf, 0);
        chk("rd2_err", err, 0);
        idx = 3'd0;
        req = 1'b1;
        tick();
        tick();
        req = 1'b0;
        chk("rd2_hold_valid", valid, 1);
        chk("rd2_hold_data", data_out, 7);
        do_ack();
        chk("rd2_ack_valid", valid, 0);
        chk("rd2_ack_data", data_out, 0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("ack_in_wait", valid, 0);

        // Saturation: 70 pops on a 6-bit counter.
        pop = 5'b00001;
        repeat (70) tick();
        pop = '0;
        do_read(0);
        chk("sat_data", data_out, 63);
        chk("sat_ovf", ovf, 1);
        chk("sat_err", err, 0);
        do_ack();
        chk("sat_ack_ovf", ovf, 0);

        // Out-of-range index.
        do_read(5);
        chk("oor_valid", valid, 1);
        chk("oor_err", err, 1);
        chk("oor_data", data_out, 0);
        chk("oor_ovf", ovf, 0);
        do_ack();
        chk("oor_ack_err", err, 0);
        do_read(2);
`ifdef CONTADOR_CLR_ON_READ_EN
        chk("oor_nochg_ch2", data_out, 0);
`else
        chk("oor_nochg_ch2", data_out, 7);
`endif
        do_ack();

        // Requests while not idle are dropped, not queued.
        idle = 1'b0;
        req  = 1'b1;
        idx  = 3'd2;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("busy_valid%0d", k), valid, 0);
        end
        idle = 1'b1;
        tick();
        req = 1'b0;
        chk("idle_accept", valid, 1);
        do_ack();

        // Pop on channel 1 coincident with the accept edge.
        pop = 5'b00010;
        repeat (4) tick();
        idle = 1'b1;
        req  = 1'b1;
        idx  = 3'd1;
        tick();
        req = 1'b0;
        pop = '0;
        chk("same_edge_data", data_out, 4);
        do_ack();
        do_read(1);
`ifdef CONTADOR_CLR_ON_READ_EN
        chk("same_edge_later", data_out, 1);
`else
        chk("same_edge_later", data_out, 5);
`endif
        do_ack();

        // Asynchronous reset in the middle of a response.
        pop = 5'b01000;
        repeat (9) tick();
        pop = '0;
        do_read(3);
        chk("pre_rst_data", data_out, 9);
        #2;
        reset_L = 1'b0;
        #1;
        chk("async_rst_valid", valid, 0);
        chk("async_rst_data", data_out, 0);
        tick();
        reset_L = 1'b1;
        tick();
        for (int c = 0; c < NUM_CH; c++) begin
            do_read(c);
            chk($sformatf("post_rst_ch%0d", c), data_out, 0);
            chk($sformatf("post_rst_ovf%0d", c), ovf, 0);
            do_ack();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
